// File: rtl/clic_pkg.sv
// clic_pkg: shared types and default sizes for the CLIC interrupt dispatcher.
// The prio field of entry_t is sized from ClicPrioLevels; dispatcher instances
// keep PrioLevels at this default so entry_t and the port widths agree.
package clic_pkg;

    localparam int unsigned ClicVecSize    = 8;
    localparam int unsigned ClicPrioLevels = 8;
    localparam int unsigned ClicStackDepth = 8;
    localparam int unsigned ClicPrioWidth  = $clog2(ClicPrioLevels);

    typedef logic [ClicPrioWidth-1:0] prio_t;

    typedef struct packed {
        logic  pended;
        logic  enable;
        prio_t prio;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Running level used for eligibility: the larger of stack top and threshold.
    function automatic prio_t prio_max(input prio_t a, input prio_t b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/clic_prio_tree.sv
// clic_prio_tree: combinational reduction over the vector table. An entry is
// eligible when pended, enabled and strictly above level_i; the result is the
// highest-priority eligible entry, lowest index winning ties.
module clic_prio_tree
    import clic_pkg::*;
#(
    parameter  int unsigned VecSize  = ClicVecSize,
    localparam int unsigned VecWidth = $clog2(VecSize)
) (
    input  entry_t [VecSize-1:0] entries_i,
    input  prio_t                level_i,
    output logic                 valid_o,
    output logic [VecWidth-1:0]  id_o,
    output prio_t                prio_o
);

    localparam int unsigned Leaves = 1 << VecWidth;
    localparam int unsigned Nodes  = 2 * Leaves - 1;

    logic                node_v  [Nodes];
    logic [VecWidth-1:0] node_id [Nodes];
    prio_t               node_p  [Nodes];

    // Heap-ordered tree: leaf k sits at Leaves-1+k; node n has children 2n+1
    // (lower indices) and 2n+2, so keeping the left child on equal priority
    // yields the lowest index on ties.
    always_comb begin
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < Nodes; i++) begin
            node_v[i]  = 1'b0;
            node_id[i] = '0;
            node_p[i]  = '0;
        end
        for (int unsigned k = 0; k < VecSize; k++) begin
            node_v[Leaves-1+k]  = entries_i[k].pended & entries_i[k].enable &
                                  (entries_i[k].prio > level_i);
            node_id[Leaves-1+k] = VecWidth'(k);
            node_p[Leaves-1+k]  = entries_i[k].prio;
        end
        for (int unsigned j = 0; j + 1 < Leaves; j++) begin
            n = Leaves - 2 - j;
            if (node_v[2*n+2] && (!node_v[2*n+1] || (node_p[2*n+2] > node_p[2*n+1]))) begin
                node_v[n]  = 1'b1;
                node_id[n] = node_id[2*n+2];
                node_p[n]  = node_p[2*n+2];
            end else begin
                node_v[n]  = node_v[2*n+1];
                node_id[n] = node_id[2*n+1];
                node_p[n]  = node_p[2*n+1];
            end
        end
    end

    assign valid_o = node_v[0];
    assign id_o    = node_id[0];
    assign prio_o  = node_p[0];

endmodule

// File: rtl/clic_dispatch.sv
// clic_dispatch: CLIC interrupt scheduler. Arbitrates the vector table against
// the running level and mintthresh, requests the winner from the core with a
// req/ack handshake, and keeps the priority-nesting stack behind stack_depth.
// Optional feature macro: CLIC_TAIL_CHAIN_EN (in IDLE, an mret cycle arbitrates
// against the post-pop level and requests on the very next cycle).
module clic_dispatch
    import clic_pkg::*;
#(
    parameter  int unsigned VecSize    = ClicVecSize,
    parameter  int unsigned PrioLevels = ClicPrioLevels,
    parameter  int unsigned StackDepth = ClicStackDepth,
    localparam int unsigned VecWidth   = $clog2(VecSize),
    localparam int unsigned PrioWidth  = $clog2(PrioLevels),
    localparam int unsigned DepthWidth = $clog2(StackDepth + 1)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [VecSize-1:0]           pended,
    input  logic [VecSize-1:0]           enable,
    input  logic [VecSize*PrioWidth-1:0] prio,
    input  logic [PrioWidth-1:0]         mintthresh,
    input  logic                         irq_ack,
    input  logic                         mret,
    output logic                         irq_req,
    output logic [VecWidth-1:0]          irq_id,
    output logic [PrioWidth-1:0]         irq_prio,
    output logic [VecSize-1:0]           clear_pend,
    output logic [PrioWidth-1:0]         cur_prio,
    output logic [DepthWidth-1:0]        stack_depth,
    output logic                         err
);

    localparam int unsigned           StkIdxW   = $clog2(StackDepth);
    localparam logic [DepthWidth-1:0] DepthFull = DepthWidth'(StackDepth);

    // Handshake / FSM state (all outputs registered)
    state_t              state_q;
    logic                irq_req_q;
    logic [VecWidth-1:0] irq_id_q;
    prio_t               irq_prio_q;
    logic [VecSize-1:0]  clear_pend_q;

    // Nesting stack
    prio_t                 stack_q [StackDepth];
    logic [DepthWidth-1:0] depth_q;
    logic [DepthWidth-1:0] depth_pop;
    logic [DepthWidth-1:0] depth_d;
    logic [StkIdxW-1:0]    rd_idx;
    logic [StkIdxW-1:0]    wr_idx;
    prio_t                 pop_top;
    prio_t                 cur_prio_q;
    prio_t                 cur_prio_d;
    logic                  do_pop;
    logic                  do_push;
    logic                  err_q;

    // Arbitration
    entry_t [VecSize-1:0] entries;
    prio_t                level_n;
    logic                 win_valid;
    logic [VecWidth-1:0]  win_id;
    prio_t                win_prio;
    logic                 win_valid_q;
    logic [VecWidth-1:0]  win_id_q;
    prio_t                win_prio_q;

    // Tail-chain bypass
    logic                 tail_take;
    logic [VecWidth-1:0]  tail_id;
    prio_t                tail_prio;

    // Unpack the flat port vectors into table entries.
    always_comb begin
        for (int unsigned k = 0; k < VecSize; k++) begin
            entries[k].pended = pended[k];
            entries[k].enable = enable[k];
            entries[k].prio   = prio[k*PrioWidth +: PrioWidth];
        end
    end

    // Stack next state: an mret pops first, then an accepted request pushes,
    // so a same-cycle mret+ack replaces the top without changing depth.
    always_comb begin
        do_pop     = mret & (depth_q != '0);
        do_push    = irq_ack & irq_req_q;
        depth_pop  = depth_q - DepthWidth'(do_pop);
        depth_d    = depth_pop + DepthWidth'(do_push);
        rd_idx     = StkIdxW'(depth_pop - DepthWidth'(1));
        wr_idx     = StkIdxW'(depth_pop);
        pop_top    = (depth_pop != '0) ? stack_q[rd_idx] : '0;
        cur_prio_d = do_push ? irq_prio_q : pop_top;
        level_n    = prio_max(cur_prio_d, mintthresh);
    end

    // Main arbiter runs against the level the stack takes on at the next edge,
    // so the registered winner is never stale after a push or pop.
    clic_prio_tree #(
        .VecSize (VecSize)
    ) u_tree (
        .entries_i (entries),
        .level_i   (level_n),
        .valid_o   (win_valid),
        .id_o      (win_id),
        .prio_o    (win_prio)
    );

`ifdef CLIC_TAIL_CHAIN_EN
    prio_t level_t;
    logic  tail_valid;

    assign level_t = prio_max(pop_top, mintthresh);

    clic_prio_tree #(
        .VecSize (VecSize)
    ) u_tail_tree (
        .entries_i (entries),
        .level_i   (level_t),
        .valid_o   (tail_valid),
        .id_o      (tail_id),
        .prio_o    (tail_prio)
    );

    assign tail_take = tail_valid & mret & (depth_pop < DepthFull);
`else
    assign tail_take = 1'b0;
    assign tail_id   = '0;
    assign tail_prio = '0;
`endif

    // Register the arbitration result (one cycle of arbitration latency).
    always_ff @(posedge clk) begin
        if (reset) begin
            win_valid_q <= 1'b0;
            win_id_q    <= '0;
            win_prio_q  <= '0;
        end else begin
            win_valid_q <= win_valid;
            win_id_q    <= win_id;
            win_prio_q  <= win_prio;
        end
    end

    // Request FSM with registered handshake outputs and clear pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            irq_req_q    <= 1'b0;
            irq_id_q     <= '0;
            irq_prio_q   <= '0;
            clear_pend_q <= '0;
        end else begin
            clear_pend_q <= '0;
            unique case (state_q)
                IDLE: begin
                    if (tail_take) begin
                        state_q    <= REQ;
                        irq_req_q  <= 1'b1;
                        irq_id_q   <= tail_id;
                        irq_prio_q <= tail_prio;
                    end else if (win_valid_q && (depth_q < DepthFull)) begin
                        state_q    <= REQ;
                        irq_req_q  <= 1'b1;
                        irq_id_q   <= win_id_q;
                        irq_prio_q <= win_prio_q;
                    end
                end
                REQ: begin
                    if (irq_ack) begin
                        state_q      <= SETTLE;
                        irq_req_q    <= 1'b0;
                        clear_pend_q <= {{(VecSize-1){1'b0}}, 1'b1} << irq_id_q;
                    end
                end
                SETTLE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q   <= IDLE;
                    irq_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Stack depth, running level and sticky underflow error.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth_q    <= '0;
            cur_prio_q <= '0;
            err_q      <= 1'b0;
        end else begin
            depth_q    <= depth_d;
            cur_prio_q <= cur_prio_d;
            if (mret && (depth_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // Stack storage; only entries below depth_q are ever read.
    always_ff @(posedge clk) begin
        if (do_push && !reset) begin
            stack_q[wr_idx] <= irq_prio_q;
        end
    end

    assign irq_req     = irq_req_q;
    assign irq_id      = irq_id_q;
    assign irq_prio    = irq_prio_q;
    assign clear_pend  = clear_pend_q;
    assign cur_prio    = cur_prio_q;
    assign stack_depth = depth_q;
    assign err         = err_q;

endmodule

// File: tb/tb_clic_dispatch.sv
// tb_clic_dispatch: directed scenarios plus randomized table contents checked
// against a behavioural model (linear-scan winner, queue-based nesting stack).
module tb_clic_dispatch;

    localparam int unsigned VS = 8;
    localparam int unsigned PW = 3;
    localparam int unsigned SD = 4;
    localparam int unsigned DW = 3;

`ifdef CLIC_TAIL_CHAIN_EN
    localparam bit TAIL = 1'b1;
`else
    localparam bit TAIL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [VS-1:0]    pended;
    logic [VS-1:0]    enable;
    logic [VS*PW-1:0] prio;
    logic [PW-1:0]    mintthresh;
    logic             irq_ack;
    logic             mret;
    logic             irq_req;
    logic [2:0]       irq_id;
    logic [PW-1:0]    irq_prio;
    logic [VS-1:0]    clear_pend;
    logic [PW-1:0]    cur_prio;
    logic [DW-1:0]    stack_depth;
    logic             err;

    clic_dispatch #(
        .VecSize    (VS),
        .PrioLevels (8),
        .StackDepth (SD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pended      (pended),
        .enable      (enable),
        .prio        (prio),
        .mintthresh  (mintthresh),
        .irq_ack     (irq_ack),
        .mret        (mret),
        .irq_req     (irq_req),
        .irq_id      (irq_id),
        .irq_prio    (irq_prio),
        .clear_pend  (clear_pend),
        .cur_prio    (cur_prio),
        .stack_depth (stack_depth),
        .err         (err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    bit          m_pend [VS];
    bit          m_en   [VS];
    int unsigned m_prio [VS];
    int unsigned m_thr;
    int unsigned m_stk [$];
    bit          m_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        for (int k = 0; k < VS; k++) begin
            pended[k]          = m_pend[k];
            enable[k]          = m_en[k];
            prio[k*PW +: PW]   = PW'(m_prio[k]);
        end
        mintthresh = PW'(m_thr);
    endtask

    task automatic clear_table();
        for (int k = 0; k < VS; k++) begin
            m_pend[k] = 1'b0;
            m_en[k]   = 1'b0;
            m_prio[k] = 0;
        end
        m_thr = 0;
        apply();
    endtask

    task automatic set_entry(input int k, input int unsigned p);
        m_pend[k] = 1'b1;
        m_en[k]   = 1'b1;
        m_prio[k] = p;
    endtask

    function automatic int unsigned model_top();
        return (m_stk.size() == 0) ? 0 : m_stk[m_stk.size()-1];
    endfunction

    function automatic void model_pop();
        if (m_stk.size() == 0) m_err = 1'b1;
        else void'(m_stk.pop_back());
    endfunction

    // Highest eligible priority, lowest index on ties, above max(top, thresh).
    function automatic void model_winner(output bit v, output int unsigned id, output int unsigned p);
        int unsigned lvl;
        lvl = (model_top() > m_thr) ? model_top() : m_thr;
        v = 1'b0; id = 0; p = 0;
        for (int k = 0; k < VS; k++) begin
            if (m_pend[k] && m_en[k] && m_prio[k] > lvl && (!v || m_prio[k] > p)) begin
                v = 1'b1; id = k; p = m_prio[k];
            end
        end
    endfunction

    task automatic chk_stack(input string tag);
        chk({tag, "_depth"}, stack_depth, m_stk.size());
        chk({tag, "_cur"},   cur_prio,    model_top());
        chk({tag, "_err"},   err,         m_err);
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; irq_ack = 1'b0; mret = 1'b0;
        tick();
        m_stk.delete();
        m_err = 1'b0;
        chk({tag, "_req"},   irq_req,    0);
        chk({tag, "_id"},    irq_id,     0);
        chk({tag, "_prio"},  irq_prio,   0);
        chk({tag, "_clr"},   clear_pend, 0);
        chk_stack(tag);
        reset = 1'b0;
    endtask

    task automatic do_ack(input string tag, input int unsigned id, input int unsigned p, input bit with_mret);
        irq_ack = 1'b1; mret = with_mret;
        tick();
        irq_ack = 1'b0; mret = 1'b0;
        if (with_mret) model_pop();
        m_stk.push_back(p);
        chk({tag, "_clr"}, clear_pend, 32'd1 << id);
        chk({tag, "_req_drop"}, irq_req, 0);
        chk_stack(tag);
        m_pend[id] = 1'b0;
        apply();
        tick();
        chk({tag, "_clr_pulse"}, clear_pend, 0);
    endtask

    task automatic do_mret(input string tag);
        mret = 1'b1;
        tick();
        mret = 1'b0;
        model_pop();
        chk_stack(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit v;
        bit exp_req;
        bit acked;
        int unsigned wid;
        int unsigned wp;
        int unsigned act;

        reset = 1'b1; irq_ack = 1'b0; mret = 1'b0;
        m_err = 1'b0;
        clear_table();
        do_reset("rst0");

        // Single request: 2-cycle latency, then ack clears entry 3
        set_entry(3, 5); apply();
        tick(); chk("d1_lat1", irq_req, 0);
        tick(); chk("d1_req", irq_req, 1);
        chk("d1_id", irq_id, 3);
        chk("d1_prio", irq_prio, 5);
        do_ack("d1_ack", 3, 5, 1'b0);
        chk("d1_clr_const", stack_depth, 1);
        do_mret("d1_mret");

        // Equal priorities: lowest index first, the other waits for mret
        clear_table(); set_entry(2, 4); set_entry(6, 4); apply();
        tick(); tick();
        chk("d2_req", irq_req, 1);
        chk("d2_id", irq_id, 2);
        do_ack("d2_ack", 2, 4, 1'b0);
        repeat (4) tick();
        chk("d2_no_tie", irq_req, 0);
        do_mret("d2_mret");
        chk("d2_post1", irq_req, TAIL ? 1 : 0);
        tick();
        chk("d2_post2", irq_req, 1);
        chk("d2_id6", irq_id, 6);
        do_ack("d2_ack6", 6, 4, 1'b0);
        do_mret("d2_mret6");

        // Preemption nesting and unwinding
        clear_table(); set_entry(0, 3); apply();
        tick(); tick();
        chk("d3_req0", irq_id, 0);
        do_ack("d3_ack0", 0, 3, 1'b0);
        set_entry(1, 6); apply();
        tick(); tick();
        chk("d3_req1", irq_req, 1);
        chk("d3_prio1", irq_prio, 6);
        do_ack("d3_ack1", 1, 6, 1'b0);
        chk("d3_depth2", stack_depth, 2);
        do_mret("d3_mret1");
        chk("d3_cur3", cur_prio, 3);
        do_mret("d3_mret0");

        // Full stack blocks requests; mret re-opens; held req; mret+ack together
        clear_table();
        for (int i = 0; i < SD; i++) begin
            set_entry(i, i + 1); apply();
            tick(); tick();
            chk("d4_fill_req", irq_req, 1);
            do_ack("d4_fill", i, i + 1, 1'b0);
        end
        set_entry(7, 7); apply();
        repeat (5) tick();
        chk("d4_full", irq_req, 0);
        do_mret("d4_mret");
        chk("d4_post1", irq_req, TAIL ? 1 : 0);
        tick();
        chk("d4_post2", irq_req, 1);
        chk("d4_id", irq_id, 7);
        do_mret("d4_held_mret");
        chk("d4_held", irq_req, 1);
        chk("d4_held_id", irq_id, 7);
        do_ack("d4_mret_ack", 7, 7, 1'b1);
        chk("d4_cur7", cur_prio, 7);
        while (m_stk.size() > 0) do_mret("d4_unwind");

        // Underflow error, then reset mid-request
        clear_table();
        do_mret("d5_underflow");
        chk("d5_err", err, 1);
        set_entry(5, 2); apply();
        tick(); tick();
        chk("d5_req", irq_req, 1);
        do_reset("d5_rst");
        clear_table();

        // Randomized table contents against the model
        for (int it = 0; it < 150; it++) begin
            if (it % 50 == 49) do_reset("rnd_rst");
            for (int k = 0; k < VS; k++) begin
                m_pend[k] = 1'($urandom_range(0, 1));
                m_en[k]   = ($urandom_range(0, 3) != 0);
                m_prio[k] = $urandom_range(0, 7);
            end
            m_thr = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 0;
            apply();
            repeat (3) tick();
            model_winner(v, wid, wp);
            exp_req = v && (m_stk.size() < SD);
            chk("rnd_req", irq_req, exp_req);
            if (exp_req) begin
                chk("rnd_id", irq_id, wid);
                chk("rnd_prio", irq_prio, wp);
            end
            act   = $urandom_range(0, 3);
            acked = 1'b0;
            if (exp_req && act != 0) begin
                do_ack("rnd_ack", wid, wp, act == 3);
                acked = 1'b1;
            end else if ($urandom_range(0, 1) == 1) begin
                do_mret("rnd_mret");
                if (exp_req) begin
                    chk("rnd_held_req", irq_req, 1);
                    chk("rnd_held_id", irq_id, wid);
                end else begin
                    tick();
                    model_winner(v, wid, wp);
                    exp_req = v && (m_stk.size() < SD);
                    chk("rnd_post_mret_req", irq_req, exp_req);
                    if (exp_req) chk("rnd_post_mret_id", irq_id, wid);
                end
            end
            if (exp_req && !acked) do_ack("rnd_late_ack", wid, wp, 1'b0);
            for (int k = 0; k < VS; k++) m_pend[k] = 1'b0;
            apply();
            repeat (3) tick();
            chk("rnd_quiet", irq_req, 0);
            repeat ($urandom_range(0, 2)) begin
                if (m_stk.size() > 0 || $urandom_range(0, 7) == 0) do_mret("rnd_unwind");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
